// File: rtl/hazard_if.sv
// hazard_if: bundle between the hazard/stall controller and the pipeline.
//   Decode/EX/memory status flows into the controller. Register enables,
//   bubble controls and status flow out of it.
//   modport master : the controller (hazard_ctrl)
//   modport slave  : the pipeline side that drives status and consumes enables
interface hazard_if;
  // status into the controller
  logic [15:0] IFID_Instr;       // instruction in decode; Rs=[10:8], Rt=[7:5]
  logic        ValidRs_ID;       // decode instruction reads Rs
  logic        ValidRt_ID;       // decode instruction reads Rt
  logic        IDEX_MemRead;     // EX instruction is a load
  logic        IDEX_RegWriteEN;  // EX instruction writes a register
  logic [2:0]  IDEX_DstRegNum;   // EX destination register
  logic        BranchTaken_EX;   // EX resolved a taken branch/jump
  logic        IMem_Stall;       // fetch not complete this cycle
  logic        DMem_Stall;       // MEM data access not complete this cycle
  // controls out of the controller
  logic        PC_WriteEN;
  logic        IFID_WriteEN;
  logic        IDEX_WriteEN;
  logic        EXMEM_WriteEN;
  logic        MEMWB_WriteEN;
  logic        IFID_Bubble;      // IF/ID loads IFID_BubbleInstr
  logic        IDEX_Bubble;      // ID/EX loads all-zero controls
  logic [15:0] IFID_BubbleInstr; // encoding IF/ID loads on a bubble
  logic        Halted;
  logic [15:0] Stall_Count;
  logic [1:0]  State;

  modport master (
    input  IFID_Instr, ValidRs_ID, ValidRt_ID, IDEX_MemRead, IDEX_RegWriteEN,
           IDEX_DstRegNum, BranchTaken_EX, IMem_Stall, DMem_Stall,
    output PC_WriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN, MEMWB_WriteEN,
           IFID_Bubble, IDEX_Bubble, IFID_BubbleInstr, Halted, Stall_Count, State
  );

  modport slave (
    output IFID_Instr, ValidRs_ID, ValidRt_ID, IDEX_MemRead, IDEX_RegWriteEN,
           IDEX_DstRegNum, BranchTaken_EX, IMem_Stall, DMem_Stall,
    input  PC_WriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN, MEMWB_WriteEN,
           IFID_Bubble, IDEX_Bubble, IFID_BubbleInstr, Halted, Stall_Count, State
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage core.
//   Owns every pipeline-register write enable, both bubble inserts and the
//   PC write enable. Sequences load-use stalls, branch squashes, memory wait
//   freezes and the HALT drain.
//   clk, rst : clock and synchronous active-high reset
//   hif      : hazard_if.master (status in, enables/bubbles/status out)
module hazard_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input logic      clk,
  input logic      rst,
  hazard_if.master hif
);
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  drain_cnt_reg, drain_cnt_next;
  logic        halted_reg;
  logic [15:0] stall_count_reg;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_bub, idex_bub;
  logic luh;

  // Opcode field is decoded through HALT_OPC; the low bits are not needed here.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, hif.IFID_Instr[4:0]};

  assign luh = hif.IDEX_MemRead & hif.IDEX_RegWriteEN &
               ((hif.ValidRs_ID & (hif.IFID_Instr[10:8] == hif.IDEX_DstRegNum)) |
                (hif.ValidRt_ID & (hif.IFID_Instr[7:5]  == hif.IDEX_DstRegNum)));

  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    exmem_we       = 1'b1;
    memwb_we       = 1'b1;
    ifid_bub       = 1'b0;
    idex_bub       = 1'b0;
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;

    if (rst) begin
      // Flow NOPs into the front of the pipe while reset is held.
      ifid_bub = 1'b1;
      idex_bub = 1'b1;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (hif.DMem_Stall) begin
            // Freeze; a held taken branch is acted on once the freeze lifts.
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
          end else if (hif.BranchTaken_EX) begin
            // Redirect writes PC; any in-flight fetch is discarded, so
            // IMem_Stall does not matter here.
            ifid_bub = 1'b1;
            idex_bub = 1'b1;
          end else if (luh) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_bub = 1'b1;
          end else if (hif.IFID_Instr[15:11] == HALT_OPC) begin
            // HALT moves on into ID/EX; fetch stops for good.
            pc_we          = 1'b0;
            ifid_bub       = 1'b1;
            drain_cnt_next = 2'd3;
            state_next     = DRAIN;
          end else if (hif.IMem_Stall) begin
            pc_we    = 1'b0;
            ifid_bub = 1'b1;
          end
        end
        DRAIN: begin
          if (hif.DMem_Stall) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
          end else begin
            pc_we          = 1'b0;
            ifid_bub       = 1'b1;
            drain_cnt_next = drain_cnt_reg - 2'd1;
            if (drain_cnt_reg == 2'd1) state_next = HALTED;
          end
        end
        default: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      drain_cnt_reg   <= 2'd0;
      halted_reg      <= 1'b0;
      stall_count_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      halted_reg    <= (state_next == HALTED);
      if ((state_reg != HALTED) && !pc_we && (stall_count_reg != 16'hFFFF))
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign hif.PC_WriteEN       = pc_we;
  assign hif.IFID_WriteEN     = ifid_we;
  assign hif.IDEX_WriteEN     = idex_we;
  assign hif.EXMEM_WriteEN    = exmem_we;
  assign hif.MEMWB_WriteEN    = memwb_we;
  assign hif.IFID_Bubble      = ifid_bub;
  assign hif.IDEX_Bubble      = idex_bub;
  assign hif.IFID_BubbleInstr = NOP_INSTR;
  assign hif.Halted           = halted_reg;
  assign hif.Stall_Count      = stall_count_reg;
  assign hif.State            = state_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl.
//   Control outputs are compared as one 7-bit word:
//   {PC_WriteEN, IFID_WriteEN, IDEX_WriteEN, EXMEM_WriteEN, MEMWB_WriteEN,
//    IFID_Bubble, IDEX_Bubble}
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_passed = 0;

  hazard_if hif ();

  hazard_ctrl #(.NOP_INSTR(16'h0800), .HALT_OPC(5'b00000)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] O_DEF    = 7'b11111_00;
  localparam logic [6:0] O_RST    = 7'b11111_11;
  localparam logic [6:0] O_LUH    = 7'b00111_01;
  localparam logic [6:0] O_BR     = 7'b11111_11;
  localparam logic [6:0] O_FETCH  = 7'b01111_10;  // IMem stall, HALT entry, drain
  localparam logic [6:0] O_FREEZE = 7'b00000_00;

  localparam logic [15:0] I_NOP   = 16'h0800;
  localparam logic [15:0] I_HALT  = 16'h0000;
  localparam logic [15:0] I_ADD11 = {5'b00010, 3'd1, 3'd2, 5'd0};  // Rs=1 Rt=2
  localparam logic [15:0] I_ADD21 = {5'b00010, 3'd2, 3'd1, 5'd0};  // Rs=2 Rt=1

  function automatic logic [6:0] outs();
    return {hif.PC_WriteEN, hif.IFID_WriteEN, hif.IDEX_WriteEN, hif.EXMEM_WriteEN,
            hif.MEMWB_WriteEN, hif.IFID_Bubble, hif.IDEX_Bubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
      $display("chk %-16s ok   obs=%0h", tag, obs);
    end else begin
      $display("FAIL %-16s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic vrs, input logic vrt,
                       input logic mrd, input logic rwe, input logic [2:0] dst,
                       input logic br, input logic ims, input logic dms);
    hif.IFID_Instr      = instr;
    hif.ValidRs_ID      = vrs;
    hif.ValidRt_ID      = vrt;
    hif.IDEX_MemRead    = mrd;
    hif.IDEX_RegWriteEN = rwe;
    hif.IDEX_DstRegNum  = dst;
    hif.BranchTaken_EX  = br;
    hif.IMem_Stall      = ims;
    hif.DMem_Stall      = dms;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(I_NOP, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    chk("rst_outs", outs(), O_RST);
    chk("nop_encoding", hif.IFID_BubbleInstr, 16'h0800);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_state", hif.State, 2'b00);
    chk("rst_halted", hif.Halted, 1'b0);
    chk("rst_count", hif.Stall_Count, 16'd0);
    chk("idle_outs", outs(), O_DEF);

    // Load-use on Rs, one stall cycle
    drive(I_ADD11, 1, 1, 1, 1, 3'd1, 0, 0, 0);
    chk("luh_rs", outs(), O_LUH);
    tick();
    drive(I_ADD11, 1, 1, 0, 0, 3'd0, 0, 0, 0);
    chk("luh_after", outs(), O_DEF);
    chk("luh_count", hif.Stall_Count, 16'd1);

    // No stall: consumer reads nothing; then producer does not write
    drive(I_ADD11, 0, 0, 1, 1, 3'd1, 0, 0, 0);
    chk("no_valid", outs(), O_DEF);
    drive(I_ADD11, 1, 0, 1, 0, 3'd1, 0, 0, 0);
    chk("no_regwr", outs(), O_DEF);
    // Load-use through Rt
    drive(I_ADD21, 0, 1, 1, 1, 3'd1, 0, 0, 0);
    chk("luh_rt", outs(), O_LUH);
    tick();
    chk("luh_rt_count", hif.Stall_Count, 16'd2);

    // Taken branch beats load-use and IMem stall
    drive(I_ADD11, 1, 1, 1, 1, 3'd1, 1, 1, 0);
    chk("branch_prio", outs(), O_BR);
    tick();
    chk("branch_count", hif.Stall_Count, 16'd2);

    // IMem stall alone
    drive(I_ADD11, 1, 1, 0, 0, 3'd0, 0, 1, 0);
    chk("imem_stall", outs(), O_FETCH);
    tick();
    chk("imem_count", hif.Stall_Count, 16'd3);

    // DMem freeze holding a taken branch for 3 cycles, then the squash
    for (int i = 0; i < 3; i++) begin
      drive(I_ADD11, 1, 1, 0, 0, 3'd0, 1, 0, 1);
      chk($sformatf("freeze_br%0d", i), outs(), O_FREEZE);
      tick();
    end
    drive(I_ADD11, 1, 1, 0, 0, 3'd0, 1, 0, 0);
    chk("squash_after", outs(), O_BR);
    chk("freeze_count", hif.Stall_Count, 16'd6);
    tick();

    // Fresh start, then HALT with no stalls
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(I_HALT, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    chk("halt_entry", outs(), O_FETCH);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(I_NOP, 0, 0, 0, 0, 3'd0, (i == 1), (i == 2), 0);
      chk($sformatf("drain_state%0d", i), hif.State, 2'b01);
      chk($sformatf("drain_outs%0d", i), outs(), O_FETCH);
      tick();
    end
    chk("halted_state", hif.State, 2'b10);
    chk("halted_flag", hif.Halted, 1'b1);
    chk("halted_outs", outs(), O_FREEZE);
    chk("halt_count", hif.Stall_Count, 16'd4);
    tick();
    tick();
    chk("halted_sticky", outs(), O_FREEZE);
    chk("halted_count2", hif.Stall_Count, 16'd4);

    // rst in HALTED returns to RUN
    rst = 1'b1;
    #1;
    chk("rst_in_halt", outs(), O_RST);
    tick();
    rst = 1'b0;
    #1;
    chk("rerun_state", hif.State, 2'b00);
    chk("rerun_halted", hif.Halted, 1'b0);
    chk("rerun_count", hif.Stall_Count, 16'd0);

    // HALT with 2 DMem stall cycles mid-drain: Halted after 6 edges
    drive(I_HALT, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    tick();                                   // entry: cnt=3
    drive(I_NOP, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    tick();                                   // cnt=2
    drive(I_NOP, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    chk("drain_freeze", outs(), O_FREEZE);
    tick();
    tick();                                   // cnt held at 2
    drive(I_NOP, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    chk("drain_resume", hif.State, 2'b01);
    tick();                                   // cnt=1
    chk("halt5_flag", hif.Halted, 1'b0);
    tick();                                   // HALTED
    chk("halt6_flag", hif.Halted, 1'b1);
    chk("halt6_count", hif.Stall_Count, 16'd6);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
